// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: instruction field positions,
// bus-source and destination codes, and the sequencer state enumeration.
package control_pkg;

  // Instruction layout: {bit7, dest[2:0], bit3, source[2:0]}
  localparam int IR_BIT7     = 7;
  localparam int IR_DEST_MSB = 6;
  localparam int IR_DEST_LSB = 4;
  localparam int IR_BIT3     = 3;
  localparam int IR_SRC_MSB  = 2;
  localparam int IR_SRC_LSB  = 0;

  // Bus source codes
  localparam logic [2:0] SRC_ROM  = 3'd0;
  localparam logic [2:0] SRC_ZERO = 3'd1;
  localparam logic [2:0] SRC_A    = 3'd2;
  localparam logic [2:0] SRC_B    = 3'd3;
  localparam logic [2:0] SRC_X    = 3'd4;
  localparam logic [2:0] SRC_RAM  = 3'd5;
  localparam logic [2:0] SRC_E    = 3'd6;
  localparam logic [2:0] SRC_S    = 3'd7;

  // Destination codes
  localparam logic [2:0] DST_IR  = 3'd0;
  localparam logic [2:0] DST_PC  = 3'd1;
  localparam logic [2:0] DST_A   = 3'd2;
  localparam logic [2:0] DST_B   = 3'd3;
  localparam logic [2:0] DST_X   = 3'd4;
  localparam logic [2:0] DST_MEM = 3'd5;
  localparam logic [2:0] DST_Q   = 3'd6;
  localparam logic [2:0] DST_QHI = 3'd7;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WAIT,
    HALT,
    FAULT
  } seqStateT;

  function automatic logic [2:0] irSource(input logic [7:0] instr);
    return instr[IR_SRC_MSB:IR_SRC_LSB];
  endfunction

  function automatic logic [2:0] irDest(input logic [7:0] instr);
    return instr[IR_DEST_MSB:IR_DEST_LSB];
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: turns the current instruction and
// the saved ALU flags into bus-enable (active-low, indexed by source) and
// load-strobe (active-high, indexed by destination) vectors.
module control_decode
  import control_pkg::*;
(
  input  logic       zeroReg,
  input  logic       carryReg,
  input  logic [7:0] instr,
  output logic [7:0] busEnBar,
  output logic [7:0] strobe,
  output logic       doJump,
  output logic       doSubtract,
  output logic       memAccess
);

  logic [2:0] src;
  logic [2:0] dst;
  logic       bit7;
  logic       bit3;

  // Decode source, destination, jump condition and memory-access flag
  always_comb begin
    src        = irSource(instr);
    dst        = irDest(instr);
    bit7       = instr[IR_BIT7];
    bit3       = instr[IR_BIT3];
    busEnBar   = 8'hFF;
    strobe     = 8'h00;
    doJump     = (dst == DST_PC) &
                 ((bit3 & zeroReg) | (bit7 & carryReg) | (~bit3 & ~bit7));
    doSubtract = bit3;
    memAccess  = (src == SRC_RAM) || (dst == DST_MEM);

    case (src)
      SRC_ROM:  busEnBar[SRC_ROM] = 1'b0;
      SRC_ZERO: busEnBar          = 8'hFF;
      SRC_A:    busEnBar[SRC_A]   = 1'b0;
      SRC_B:    busEnBar[SRC_B]   = 1'b0;
      SRC_X:    busEnBar[SRC_X]   = 1'b0;
      SRC_RAM:  busEnBar[SRC_RAM] = 1'b0;
      SRC_E:    busEnBar[SRC_E]   = 1'b0;
      SRC_S:    busEnBar[SRC_S]   = 1'b0;
      default:  busEnBar          = 8'hFF;
    endcase

    case (dst)
      DST_IR:  strobe[DST_IR]  = 1'b1;
      DST_PC:  strobe[DST_PC]  = doJump;
      DST_A:   strobe[DST_A]   = 1'b1;
      DST_B:   strobe[DST_B]   = 1'b1;
      DST_X:   strobe[DST_X]   = 1'b1;
      DST_MEM: strobe[DST_MEM] = 1'b1;
      DST_Q:   strobe[DST_Q]   = 1'b1;
      DST_QHI: strobe[DST_QHI] = 1'b1;
      default: strobe          = 8'h00;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Microcoded-style control sequencer: FETCH loads the instruction register,
// EXEC drives one bus source and one load strobe, memory instructions stall
// in WAIT until memReady (or fault after TIMEOUT cycles).
// Optional feature macro: CONTROL_SEQ_HALT_EN makes opcode 8'hFF halt the
// sequencer until reset; without it 8'hFF is an ordinary S -> Qhi move.
module control_seq
  import control_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             aluZero,
  input  logic             aluCarry,
  input  logic             memReady,
  output logic             memReq,
  output logic             assertBarRom,
  output logic             assertBarA,
  output logic             assertBarB,
  output logic             assertBarX,
  output logic             assertBarRam,
  output logic             assertBarE,
  output logic             assertBarS,
  output logic             loadPC,
  output logic             loadA,
  output logic             loadB,
  output logic             loadX,
  output logic             storeMem,
  output logic             loadQ,
  output logic             loadQhi,
  output logic             incPC,
  output logic             doSubtract,
  output logic             doJump,
  output logic [7:0]       ir,
  output logic             halted,
  output logic             fault
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  seqStateT   state;
  logic       zeroReg;
  logic       carryReg;
  logic [7:0] waitCount;
  logic [7:0] decBus;
  logic [7:0] decStrobe;
  logic       decJump;
  logic       decSub;
  logic       decMem;
  logic       haltInstr;
  logic [7:0] busEnBar;
  logic [7:0] strobeVec;
  logic       unusedBits;

  control_decode decoder (
    .zeroReg   (zeroReg),
    .carryReg  (carryReg),
    .instr     (ir),
    .busEnBar  (decBus),
    .strobe    (decStrobe),
    .doJump    (decJump),
    .doSubtract(decSub),
    .memAccess (decMem)
  );

`ifdef CONTROL_SEQ_HALT_EN
  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  assign haltInstr = (ir == HALT_OPCODE);
  assign halted    = (state == HALT);
`else
  assign haltInstr = 1'b0;
  assign halted    = 1'b0;
`endif

  assign fault = (state == FAULT);

  // Upper bus bits and the "zero" source select have no consumer here
  assign unusedBits = ^{dataIn, busEnBar[SRC_ZERO]};

  // Gate the decoded controls by state; memory strobes wait for memReady
  always_comb begin
    busEnBar   = 8'hFF;
    strobeVec  = 8'h00;
    incPC      = 1'b0;
    memReq     = 1'b0;
    doSubtract = 1'b0;
    doJump     = 1'b0;
    case (state)
      FETCH: begin
        busEnBar[SRC_ROM] = 1'b0;
        incPC             = resetBar;
      end
      EXEC, WAIT: begin
        if (!haltInstr) begin
          busEnBar   = decBus;
          doSubtract = decSub;
          doJump     = decJump;
          memReq     = decMem;
          if (!decMem || memReady) strobeVec = decStrobe;
        end
      end
      default: begin
        busEnBar  = 8'hFF;
        strobeVec = 8'h00;
      end
    endcase
  end

  assign assertBarRom = busEnBar[SRC_ROM];
  assign assertBarA   = busEnBar[SRC_A];
  assign assertBarB   = busEnBar[SRC_B];
  assign assertBarX   = busEnBar[SRC_X];
  assign assertBarRam = busEnBar[SRC_RAM];
  assign assertBarE   = busEnBar[SRC_E];
  assign assertBarS   = busEnBar[SRC_S];

  assign loadPC   = strobeVec[DST_PC];
  assign loadA    = strobeVec[DST_A];
  assign loadB    = strobeVec[DST_B];
  assign loadX    = strobeVec[DST_X];
  assign storeMem = strobeVec[DST_MEM];
  assign loadQ    = strobeVec[DST_Q];
  assign loadQhi  = strobeVec[DST_QHI];

  // Sequencer state, instruction register, ALU flags and WAIT counter
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state     <= FETCH;
      ir        <= 8'h00;
      zeroReg   <= 1'b0;
      carryReg  <= 1'b0;
      waitCount <= 8'h00;
    end else begin
      if (strobeVec[DST_A]) begin
        zeroReg  <= aluZero;
        carryReg <= aluCarry;
      end
      if (strobeVec[DST_IR]) ir <= dataIn[7:0];
      case (state)
        FETCH: begin
          ir    <= dataIn[7:0];
          state <= EXEC;
        end
        EXEC: begin
          waitCount <= 8'h00;
          if (haltInstr)               state <= HALT;
          else if (decMem && !memReady) state <= WAIT;
          else                         state <= FETCH;
        end
        WAIT: begin
          if (memReady)                       state <= FETCH;
          else if (waitCount == TIMEOUT_LAST) state <= FAULT;
          else                                waitCount <= waitCount + 8'd1;
        end
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: a table of single instructions checked
// through an expected-result queue, plus hand-written sequences for memory
// stalls, timeout fault, reset during WAIT and the 8'hFF opcode.
module tb_control_seq;

  localparam int WIDTH   = 12;
  localparam int TIMEOUT = 4;
  localparam int NVEC    = 14;

  logic             clk = 1'b0;
  logic             resetBar;
  logic [WIDTH-1:0] dataIn;
  logic             aluZero;
  logic             aluCarry;
  logic             memReady;
  logic             memReq;
  logic             assertBarRom, assertBarA, assertBarB, assertBarX;
  logic             assertBarRam, assertBarE, assertBarS;
  logic             loadPC, loadA, loadB, loadX, storeMem, loadQ, loadQhi, incPC;
  logic             doSubtract, doJump;
  logic [7:0]       ir;
  logic             halted, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] instr;
    logic       zero;
    logic       carry;
    logic [7:0] expBus;
    logic [7:0] expStrobe;
    logic       expJump;
    logic       expSub;
    logic       expMemReq;
  } vecT;

  vecT vecs[NVEC];
  vecT expQ[$];
  vecT expItem;

  wire [7:0] busVec = {assertBarS, assertBarE, assertBarRam, assertBarX,
                       assertBarB, assertBarA, 1'b1, assertBarRom};
  wire [7:0] strobeVec = {loadQhi, loadQ, storeMem, loadX, loadB, loadA, loadPC, 1'b0};

  control_seq #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .resetBar    (resetBar),
    .dataIn      (dataIn),
    .aluZero     (aluZero),
    .aluCarry    (aluCarry),
    .memReady    (memReady),
    .memReq      (memReq),
    .assertBarRom(assertBarRom),
    .assertBarA  (assertBarA),
    .assertBarB  (assertBarB),
    .assertBarX  (assertBarX),
    .assertBarRam(assertBarRam),
    .assertBarE  (assertBarE),
    .assertBarS  (assertBarS),
    .loadPC      (loadPC),
    .loadA       (loadA),
    .loadB       (loadB),
    .loadX       (loadX),
    .storeMem    (storeMem),
    .loadQ       (loadQ),
    .loadQhi     (loadQhi),
    .incPC       (incPC),
    .doSubtract  (doSubtract),
    .doJump      (doJump),
    .ir          (ir),
    .halted      (halted),
    .fault       (fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // At the next negedge (a FETCH cycle) present an instruction and check FETCH outputs
  task automatic applyStimulus(input logic [7:0] instr, input string tag);
    @(negedge clk);
    dataIn   = {4'($urandom_range(0, 15)), instr};
    memReady = 1'b0;
    #1;
    checkOutput({tag, " fetch incPC"}, incPC, 1'b1);
    checkOutput({tag, " fetch bus"}, busVec, 8'hFE);
    checkOutput({tag, " fetch strobes"}, strobeVec, 8'h00);
  endtask

  // Release reset shortly after a rising edge so the next edge performs FETCH
  task automatic releaseReset();
    @(posedge clk);
    #2;
    resetBar = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{8'h24, 1'b1, 1'b0, 8'hEF, 8'h04, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h18, 1'b0, 1'b0, 8'hFE, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 1'b0, 1'b0, 8'hFE, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h90, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h2B, 1'b0, 1'b1, 8'hF7, 8'h04, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h90, 1'b0, 1'b0, 8'hFE, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h18, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h98, 1'b0, 1'b0, 8'hFE, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{8'h3C, 1'b0, 1'b0, 8'hEF, 8'h08, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h47, 1'b0, 1'b0, 8'h7F, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h52, 1'b0, 1'b0, 8'hFB, 8'h20, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h61, 1'b0, 1'b0, 8'hFF, 8'h40, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h76, 1'b0, 1'b0, 8'hBF, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h35, 1'b0, 1'b0, 8'hDF, 8'h08, 1'b0, 1'b0, 1'b1};

    resetBar = 1'b0;
    dataIn   = '0;
    aluZero  = 1'b0;
    aluCarry = 1'b0;
    memReady = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    checkOutput("reset ir", ir, 8'h00);
    checkOutput("reset fault", fault, 1'b0);
    checkOutput("reset halted", halted, 1'b0);
    checkOutput("reset memReq", memReq, 1'b0);
    checkOutput("reset strobes", strobeVec, 8'h00);
    checkOutput("reset incPC", incPC, 1'b0);
    checkOutput("reset bus", busVec[7:1], 7'h7F);
    releaseReset();

    // Table of single-cycle EXEC instructions, memReady already high
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].instr, $sformatf("v%0d", i));
      expQ.push_back(vecs[i]);
      @(negedge clk);
      aluZero  = vecs[i].zero;
      aluCarry = vecs[i].carry;
      memReady = 1'b1;
      #1;
      if (expQ.size() == 0) begin
        checkOutput($sformatf("v%0d queue empty", i), 32'd0, 32'd1);
      end else begin
        expItem = expQ.pop_front();
        checkOutput($sformatf("v%0d ir", i), ir, expItem.instr);
        checkOutput($sformatf("v%0d bus", i), busVec, expItem.expBus);
        checkOutput($sformatf("v%0d strobes", i), strobeVec, expItem.expStrobe);
        checkOutput($sformatf("v%0d doJump", i), doJump, expItem.expJump);
        checkOutput($sformatf("v%0d doSubtract", i), doSubtract, expItem.expSub);
        checkOutput($sformatf("v%0d memReq", i), memReq, expItem.expMemReq);
      end
    end
    // Flags now zero=0 carry=1

    // Ram -> A with memReady low three cycles then high; sets zero flag
    applyStimulus(8'h25, "memwait");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      memReady = (i == 3);
      aluZero  = 1'b1;
      aluCarry = 1'b0;
      #1;
      checkOutput($sformatf("memwait c%0d memReq", i), memReq, 1'b1);
      checkOutput($sformatf("memwait c%0d loadA", i), loadA, (i == 3));
      checkOutput($sformatf("memwait c%0d bus", i), busVec, 8'hDF);
    end
    applyStimulus(8'h18, "jzAfterWait");
    @(negedge clk);
    #1;
    checkOutput("jzAfterWait doJump", doJump, 1'b1);
    checkOutput("jzAfterWait loadPC", loadPC, 1'b1);

    // Reset asserted mid-WAIT abandons the access
    applyStimulus(8'h25, "resetWait");
    @(negedge clk);
    memReady = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("resetWait before memReq", memReq, 1'b1);
    #1;
    resetBar = 1'b0;
    memReady = 1'b1;
    #1;
    checkOutput("resetWait memReq", memReq, 1'b0);
    checkOutput("resetWait strobes", strobeVec, 8'h00);
    checkOutput("resetWait incPC", incPC, 1'b0);
    releaseReset();
    applyStimulus(8'h24, "afterReset");
    @(negedge clk);
    aluZero  = 1'b0;
    aluCarry = 1'b0;
    memReady = 1'b0;
    #1;
    checkOutput("afterReset ir", ir, 8'h24);
    checkOutput("afterReset loadA", loadA, 1'b1);
    checkOutput("afterReset bus", busVec, 8'hEF);

    // Timeout: memReady never arrives
    applyStimulus(8'h25, "timeout");
    @(negedge clk);
    #1;
    checkOutput("timeout exec memReq", memReq, 1'b1);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("timeout w%0d memReq", i), memReq, 1'b1);
      checkOutput($sformatf("timeout w%0d fault", i), fault, 1'b0);
      checkOutput($sformatf("timeout w%0d loadA", i), loadA, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memReady = 1'b1;
      #1;
      checkOutput($sformatf("fault c%0d fault", i), fault, 1'b1);
      checkOutput($sformatf("fault c%0d memReq", i), memReq, 1'b0);
      checkOutput($sformatf("fault c%0d strobes", i), strobeVec, 8'h00);
      checkOutput($sformatf("fault c%0d incPC", i), incPC, 1'b0);
      checkOutput($sformatf("fault c%0d bus", i), busVec, 8'hFF);
    end
    resetBar = 1'b0;
    #1;
    checkOutput("fault cleared", fault, 1'b0);
    releaseReset();

    // Opcode 8'hFF
    applyStimulus(8'hFF, "opFF");
    @(negedge clk);
    #1;
`ifdef CONTROL_SEQ_HALT_EN
    checkOutput("opFF exec strobes", strobeVec, 8'h00);
    checkOutput("opFF exec memReq", memReq, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("halt c%0d halted", i), halted, 1'b1);
      checkOutput($sformatf("halt c%0d strobes", i), strobeVec, 8'h00);
      checkOutput($sformatf("halt c%0d incPC", i), incPC, 1'b0);
      checkOutput($sformatf("halt c%0d memReq", i), memReq, 1'b0);
    end
`else
    checkOutput("opFF bus", busVec, 8'h7F);
    checkOutput("opFF strobes", strobeVec, 8'h80);
    checkOutput("opFF doSubtract", doSubtract, 1'b1);
    checkOutput("opFF halted", halted, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("opFF next fetch", incPC, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter: WIDTH, 8, data-bus width; IR captures dataIn[7:0]; WIDTH SHALL be >= 8.
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles before fault; 1..255.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetBar  input  1  asynchronous, active-low reset.
REQ-005 dataIn  input  WIDTH  bus value; low 8 bits are the instruction during FETCH.
REQ-006 aluZero, aluCarry  input  1 each  ALU result flags, sampled when A loads.
REQ-007 memReady  input  1  RAM handshake completion.
REQ-008 memReq  output  1  RAM access request.
REQ-009 assertBarRom, assertBarA, assertBarB, assertBarX, assertBarRam, assertBarE, assertBarS  output  1 each  active-low bus-source enables.
REQ-010 loadPC, loadA, loadB, loadX, storeMem, loadQ, loadQhi, incPC  output  1 each  active-high one-cycle load strobes.
REQ-011 doSubtract, doJump  output  1 each  ALU mode; taken jump.
REQ-012 ir  output  8  current instruction; halted, fault  output  1 each  status.

Function
REQ-013 IR fields: {bit7, dest[2:0], bit3, source[2:0]}; source 0..7 = Rom, zero, A, B, X, Ram, E, S; dest 0..7 = IR, PC, A, B, X, Mem, Q, Qhi.
REQ-014 States: FETCH, EXEC, WAIT, HALT, FAULT; encoding SHALL be internal.
REQ-015 FETCH: assertBarRom=0, incPC=1; IR <= dataIn[7:0]; next EXEC.
REQ-016 EXEC: exactly one assertBar low per source (source 1 asserts none; the bus reads zero); exactly one strobe high per dest, except dest 1, which strobes loadPC only when doJump.
REQ-017 doJump = (dest==1) & ((bit3 & zeroReg) | (bit7 & carryReg) | (~bit3 & ~bit7)); doSubtract = bit3 in EXEC only.
REQ-018 Memory instruction (source==5 or dest==5): memReq=1 in EXEC; memReady in the same cycle -> FETCH, else -> WAIT.
REQ-019 WAIT: memReq and all EXEC outputs held; strobes SHALL fire only in the cycle where memReady=1; memReady -> FETCH.
REQ-020 WAIT counter SHALL start at 0 on entry and increment each WAIT cycle; reaching TIMEOUT without memReady -> FAULT.
REQ-021 FAULT: fault=1, all strobes 0, all assertBar 1, memReq 0; sticky until reset.
REQ-022 Flags: on a loadA strobe, zeroReg <= aluZero and carryReg <= aluCarry; a jump uses the pre-update flag values.
REQ-023 Latency: non-memory instruction 2 cycles; memory instruction 2 + n, where n is the count of WAIT cycles.
REQ-024 Outside EXEC and WAIT, all strobes SHALL be 0 and doSubtract/doJump SHALL be 0.

Reset
REQ-025 resetBar low SHALL immediately force: state FETCH, IR 0, zeroReg/carryReg 0, counter 0, memReq 0, halted 0, fault 0, all strobes 0, all assertBar 1 except assertBarRom, which follows FETCH after release.
REQ-026 Reset asserted mid-WAIT SHALL abandon the access with no strobe.
REQ-027 After resetBar is released, the first rising edge SHALL perform FETCH.

Configuration
REQ-028 Macro CONTROL_SEQ_HALT_EN: when defined, ir==8'hFF in EXEC enters HALT (halted=1, no strobes, no memReq) until reset; when undefined, 8'hFF executes normally (source S -> dest Qhi) and halted is tied 0.

Structure
REQ-029 Shared package control_pkg SHALL hold: source and dest field constants, the state enumeration, and the IR field-position constants.
REQ-030 Sub-module control_decode SHALL be purely combinational: IR plus flags -> assertBar/strobe/doJump vectors; control_seq SHALL own all sequential state.

Verification
REQ-031 Reset, then dataIn=8'h24 (source X, dest A) -> FETCH: incPC=1; EXEC: assertBarX=0, loadA=1; aluZero=1 -> zeroReg=1.
REQ-032 zeroReg=1, ir=8'h18 (JZ) -> doJump=1, loadPC=1; zeroReg=0 -> doJump=0, loadPC=0.
REQ-033 ir=8'h25 (Ram -> A), memReady low 3 cycles then high -> memReq high 4 cycles, loadA pulses once in the 4th cycle, then FETCH.
REQ-034 TIMEOUT=4, memReady never high -> fault=1 after 4 WAIT cycles, outputs idle; resetBar pulse clears fault.
REQ-035 resetBar low during WAIT -> memReq=0 and no strobe, asynchronously; FETCH on the first edge after release.
REQ-036 With CONTROL_SEQ_HALT_EN, ir=8'hFF -> halted=1 and no strobe for 10 cycles; without the macro -> assertBarS=0, loadQhi=1.
